// File: rtl/ps2_kbd_pkg.sv
// Shared FSM state encoding and Set-2 scan-code constants for the PS/2 scan-code decoder.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EMIT,
    LED_CMD,
    LED_WAIT1,
    LED_DATA,
    LED_WAIT2
  } state_t;

  localparam logic [7:0] E0     = 8'hE0;
  localparam logic [7:0] F0     = 8'hF0;
  localparam logic [7:0] FA     = 8'hFA;
  localparam logic [7:0] AA     = 8'hAA;
  localparam logic [7:0] ED     = 8'hED;
  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CTRL   = 8'h14;
  localparam logic [7:0] CAPS   = 8'h58;

  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_TAB   = 8'h0D;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  // Keyboard LED byte: bit 2 is CapsLock, Scroll/Num stay off.
  function automatic logic [7:0] led_mask(input logic caps);
    return {5'b00000, caps, 2'b00};
  endfunction

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational Set-2 make-code to ASCII lookup covering letters, the digit row and a few control keys.
module ps2_set2_to_ascii
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic [7:0] ascii
);

  logic       is_letter;
  logic [4:0] letter;
  logic       is_digit;
  logic [3:0] digit;
  logic [7:0] shifted_digit;

  always_comb begin
    is_letter = 1'b1;
    letter    = 5'd0;
    case (code)
      8'h1C: letter = 5'd0;
      8'h32: letter = 5'd1;
      8'h21: letter = 5'd2;
      8'h23: letter = 5'd3;
      8'h24: letter = 5'd4;
      8'h2B: letter = 5'd5;
      8'h34: letter = 5'd6;
      8'h33: letter = 5'd7;
      8'h43: letter = 5'd8;
      8'h3B: letter = 5'd9;
      8'h42: letter = 5'd10;
      8'h4B: letter = 5'd11;
      8'h3A: letter = 5'd12;
      8'h31: letter = 5'd13;
      8'h44: letter = 5'd14;
      8'h4D: letter = 5'd15;
      8'h15: letter = 5'd16;
      8'h2D: letter = 5'd17;
      8'h1B: letter = 5'd18;
      8'h2C: letter = 5'd19;
      8'h3C: letter = 5'd20;
      8'h2A: letter = 5'd21;
      8'h1D: letter = 5'd22;
      8'h22: letter = 5'd23;
      8'h35: letter = 5'd24;
      8'h1A: letter = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (code)
      8'h45: digit = 4'd0;
      8'h16: digit = 4'd1;
      8'h1E: digit = 4'd2;
      8'h26: digit = 4'd3;
      8'h25: digit = 4'd4;
      8'h2E: digit = 4'd5;
      8'h36: digit = 4'd6;
      8'h3D: digit = 4'd7;
      8'h3E: digit = 4'd8;
      8'h46: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  // US layout symbols above the digit row.
  always_comb begin
    shifted_digit = 8'h00;
    case (digit)
      4'd0: shifted_digit = 8'h29;
      4'd1: shifted_digit = 8'h21;
      4'd2: shifted_digit = 8'h40;
      4'd3: shifted_digit = 8'h23;
      4'd4: shifted_digit = 8'h24;
      4'd5: shifted_digit = 8'h25;
      4'd6: shifted_digit = 8'h5E;
      4'd7: shifted_digit = 8'h26;
      4'd8: shifted_digit = 8'h2A;
      4'd9: shifted_digit = 8'h28;
      default: shifted_digit = 8'h00;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (is_letter) begin
      if (ctrl)
        ascii = {3'b000, letter} + 8'd1;
      else if (shift ^ caps)
        ascii = 8'h41 + {3'b000, letter};
      else
        ascii = 8'h61 + {3'b000, letter};
    end else if (is_digit) begin
      ascii = shift ? shifted_digit : (8'h30 + {4'b0000, digit});
    end else begin
      case (code)
        KEY_SPACE: ascii = 8'h20;
        KEY_ENTER: ascii = 8'h0D;
        KEY_BKSP:  ascii = 8'h08;
        KEY_TAB:   ascii = 8'h09;
        KEY_ESC:   ascii = 8'h1B;
        default:   ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Drains Set-2 bytes from the PS/2 controller FIFO, tracks modifiers, emits key events
// and rewrites the keyboard LEDs whenever CapsLock toggles.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter logic [19:0] ACK_TIMEOUT = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_read,
  output logic       kb_send,
  output logic [7:0] kb_senddata,
  output logic       key_valid,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic       shift,
  output logic       ctrl,
  output logic       capslock
);

  state_t      state;
  logic [7:0]  byte_q;
  logic        ext;
  logic        brk;
  logic        caps_held;
  logic        led_pend;
  logic        lshift;
  logic        rshift;
  logic        lctrl;
  logic        rctrl;
  logic [19:0] timer;
  logic [7:0]  ascii;
  logic        can_pop;

  assign shift = lshift | rshift;
  assign ctrl  = lctrl | rctrl;

  // A pop issued last cycle has not yet been reflected in kb_ready, so never pop twice in a row.
  assign can_pop = kb_ready && !kb_read;

  ps2_set2_to_ascii u_ascii (
    .code  (byte_q),
    .shift (shift),
    .caps  (capslock),
    .ctrl  (ctrl),
    .ascii (ascii)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_q      <= 8'h00;
      ext         <= 1'b0;
      brk         <= 1'b0;
      caps_held   <= 1'b0;
      led_pend    <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      lctrl       <= 1'b0;
      rctrl       <= 1'b0;
      capslock    <= 1'b0;
      timer       <= 20'd0;
      kb_read     <= 1'b0;
      kb_send     <= 1'b0;
      kb_senddata <= 8'h00;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_break   <= 1'b0;
      key_ascii   <= 8'h00;
    end else begin
      kb_read <= 1'b0;
      kb_send <= 1'b0;
      case (state)
        IDLE: begin
          if (led_pend) begin
            kb_send     <= 1'b1;
            kb_senddata <= ED;
            state       <= LED_CMD;
          end else if (can_pop) begin
            byte_q  <= kb_data;
            kb_read <= 1'b1;
            state   <= DECODE;
          end
        end

        DECODE: begin
          if (byte_q == E0) begin
            ext   <= 1'b1;
            state <= IDLE;
          end else if (byte_q == F0) begin
            brk   <= 1'b1;
            state <= IDLE;
          end else if ((byte_q == FA || byte_q == AA) && !led_pend) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            state <= IDLE;
          end else begin
            if (!ext && byte_q == LSHIFT) lshift <= !brk;
            if (!ext && byte_q == RSHIFT) rshift <= !brk;
            if (byte_q == CTRL) begin
              if (ext) rctrl <= !brk;
              else     lctrl <= !brk;
            end
            // Typematic repeats arrive with caps_held already set, so only the first make toggles.
            if (byte_q == CAPS) begin
              caps_held <= !brk;
              if (!brk && !caps_held) begin
                capslock <= !capslock;
                led_pend <= 1'b1;
              end
            end
            key_valid <= 1'b1;
            key_code  <= byte_q;
            key_ext   <= ext;
            key_break <= brk;
            key_ascii <= (brk || ext) ? 8'h00 : ascii;
            ext       <= 1'b0;
            brk       <= 1'b0;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (key_ack) begin
            key_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        LED_CMD: begin
          timer <= 20'd0;
          state <= LED_WAIT1;
        end

        LED_DATA: begin
          timer <= 20'd0;
          state <= LED_WAIT2;
        end

        LED_WAIT1, LED_WAIT2: begin
          if (can_pop) kb_read <= 1'b1;
          if (can_pop && kb_data == FA) begin
            if (state == LED_WAIT1) begin
              kb_send     <= 1'b1;
              kb_senddata <= led_mask(capslock);
              state       <= LED_DATA;
            end else begin
              led_pend <= 1'b0;
              state    <= IDLE;
            end
          end else if (timer >= ACK_TIMEOUT - 20'd1) begin
            led_pend <= 1'b0;
            state    <= IDLE;
          end else if (timer != 20'hFFFFF) begin
            timer <= timer + 20'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for the PS/2 scan-code decoder: a queue stands in for the controller FIFO.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_read;
  logic       kb_send;
  logic [7:0] kb_senddata;
  logic       key_valid;
  logic       key_ack;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic       shift;
  logic       ctrl;
  logic       capslock;

  logic [7:0] fifo[$];
  logic [7:0] sends[$];
  int         reads_cnt = 0;
  int         errors = 0;
  int         checks = 0;

  ps2_scancode_decoder #(.ACK_TIMEOUT(20'd100)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_read     (kb_read),
    .kb_send     (kb_send),
    .kb_senddata (kb_senddata),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .key_ascii   (key_ascii),
    .shift       (shift),
    .ctrl        (ctrl),
    .capslock    (capslock)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    kb_ready = (fifo.size() != 0);
    kb_data  = kb_ready ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  // One clock: apply the pop seen during the cycle, then sample outputs 1ns after the edge.
  task automatic step();
    logic rd;
    rd = kb_read;
    @(posedge clk);
    #1;
    if (rd === 1'b1) begin
      reads_cnt++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    if (kb_send === 1'b1) sends.push_back(kb_senddata);
    refresh();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_event(input int max_cycles, output bit ok);
    for (int i = 0; i < max_cycles && key_valid !== 1'b1; i++) step();
    ok = (key_valid === 1'b1);
  endtask

  task automatic wait_sends(input int n, input int max_cycles, output bit ok);
    for (int i = 0; i < max_cycles && sends.size() < n; i++) step();
    ok = (sends.size() >= n);
  endtask

  task automatic ack();
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_ack = 1'b0;
    fifo.delete();
    refresh();
    steps(3);
    checks++;
    if ({kb_read, kb_send, key_valid, shift, ctrl, capslock} !== 6'b0)
      begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {kb_read, kb_send, key_valid, shift, ctrl, capslock}); end
    checks++;
    if ({kb_senddata, key_code, key_ascii, key_ext, key_break} !== 26'h0)
      begin errors++; $display("[TB] FAIL reset_fields: got %h expected 0", {kb_senddata, key_code, key_ascii, key_ext, key_break}); end
    rst = 1'b0;
    reads_cnt = 0;
    steps(5);
    checks++;
    if (key_valid !== 1'b0 || reads_cnt != 0)
      begin errors++; $display("[TB] FAIL idle_quiet: got valid=%b reads=%0d expected valid=0 reads=0", key_valid, reads_cnt); end
  endtask

  task automatic test_make_break();
    bit ok;
    push(8'h1C);
    wait_event(20, ok);
    checks++;
    if (!ok || {key_ext, key_break, key_code, key_ascii} !== {1'b0, 1'b0, 8'h1C, 8'h61})
      begin errors++; $display("[TB] FAIL make_a: got ok=%0d %h expected ok=1 %h", ok, {key_ext, key_break, key_code, key_ascii}, {1'b0, 1'b0, 8'h1C, 8'h61}); end
    ack();
    checks++;
    if (key_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL valid_drop: got %b expected 0", key_valid); end
    push(8'hF0);
    push(8'h1C);
    wait_event(20, ok);
    checks++;
    if (!ok || {key_ext, key_break, key_code, key_ascii} !== {1'b0, 1'b1, 8'h1C, 8'h00})
      begin errors++; $display("[TB] FAIL break_a: got ok=%0d %h expected ok=1 %h", ok, {key_ext, key_break, key_code, key_ascii}, {1'b0, 1'b1, 8'h1C, 8'h00}); end
    ack();
  endtask

  task automatic test_modifiers();
    bit ok;
    int got;
    // Per event: {break, ext, shift, ctrl, code, ascii}.
    logic [19:0] expv[10] = '{20'h2_1200, 20'h2_1C41, 20'hA_1C00, 20'h8_1200, 20'h1_1400,
                              20'h1_2103, 20'h9_2100, 20'h8_1400, 20'h5_1400, 20'hC_1400};
    logic [7:0] bytes[17] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h14, 8'h21, 8'hF0,
                              8'h21, 8'hF0, 8'h14, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14};
    for (int i = 0; i < 17; i++) push(bytes[i]);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      wait_event(30, ok);
      if (ok) got++;
      checks++;
      if (!ok || {key_break, key_ext, shift, ctrl, key_code, key_ascii} !== expv[i])
        begin errors++; $display("[TB] FAIL modifier_event%0d: got ok=%0d %h expected %h", i, ok, {key_break, key_ext, shift, ctrl, key_code, key_ascii}, expv[i]); end
      ack();
    end
    steps(10);
    checks++;
    if (got != 10 || key_valid !== 1'b0 || fifo.size() != 0)
      begin errors++; $display("[TB] FAIL modifier_count: got events=%0d valid=%b left=%0d expected 10/0/0", got, key_valid, fifo.size()); end
  endtask

  task automatic test_capslock();
    bit ok;
    sends.delete();
    push(8'h58);
    wait_event(20, ok);
    checks++;
    if (!ok || {key_break, key_code, key_ascii, capslock} !== {1'b0, 8'h58, 8'h00, 1'b1})
      begin errors++; $display("[TB] FAIL caps_make: got ok=%0d %h expected %h", ok, {key_break, key_code, key_ascii, capslock}, {1'b0, 8'h58, 8'h00, 1'b1}); end
    ack();
    wait_sends(1, 20, ok);
    checks++;
    if (!ok || sends[0] !== 8'hED)
      begin errors++; $display("[TB] FAIL led_cmd: got n=%0d byte=%h expected n=1 byte=ed", sends.size(), sends[0]); end
    push(8'hFA);
    wait_sends(2, 20, ok);
    checks++;
    if (!ok || sends[1] !== 8'h04)
      begin errors++; $display("[TB] FAIL led_data: got n=%0d byte=%h expected n=2 byte=04", sends.size(), sends[1]); end
    push(8'hFA);
    steps(10);
    push(8'hF0);
    push(8'h58);
    wait_event(20, ok);
    checks++;
    if (!ok || {key_break, key_code, capslock} !== {1'b1, 8'h58, 1'b1})
      begin errors++; $display("[TB] FAIL caps_break: got ok=%0d %h expected %h", ok, {key_break, key_code, capslock}, {1'b1, 8'h58, 1'b1}); end
    ack();
    push(8'h1C);
    wait_event(20, ok);
    checks++;
    if (!ok || key_ascii !== 8'h41)
      begin errors++; $display("[TB] FAIL caps_upper: got ok=%0d ascii=%h expected 41", ok, key_ascii); end
    ack();
    steps(10);
    checks++;
    if (sends.size() != 2)
      begin errors++; $display("[TB] FAIL led_send_count: got %0d expected 2", sends.size()); end
  endtask

  task automatic test_typematic();
    bit ok;
    int bad;
    sends.delete();
    push(8'h58);
    wait_event(20, ok);
    ack();
    wait_sends(1, 20, ok);
    push(8'hFA);
    wait_sends(2, 20, ok);
    push(8'hFA);
    steps(10);
    bad = 0;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) push(8'hF0);
      push(8'h58);
      wait_event(20, ok);
      if (!ok || capslock !== 1'b0) bad++;
      ack();
    end
    steps(20);
    checks++;
    if (bad != 0 || capslock !== 1'b0)
      begin errors++; $display("[TB] FAIL typematic_caps: got bad=%0d caps=%b expected 0/0", bad, capslock); end
    checks++;
    if (sends.size() != 2 || sends[0] !== 8'hED || sends[1] !== 8'h00)
      begin errors++; $display("[TB] FAIL typematic_sends: got n=%0d %h %h expected n=2 ed 00", sends.size(), sends[0], sends[1]); end
  endtask

  task automatic test_ext_hold();
    bit ok;
    int bad;
    int reads0;
    logic [17:0] snap;
    push(8'hE0);
    push(8'h75);
    wait_event(20, ok);
    checks++;
    if (!ok || {key_ext, key_break, key_code, key_ascii} !== {1'b1, 1'b0, 8'h75, 8'h00})
      begin errors++; $display("[TB] FAIL ext_event: got ok=%0d %h expected %h", ok, {key_ext, key_break, key_code, key_ascii}, {1'b1, 1'b0, 8'h75, 8'h00}); end
    snap = {key_ext, key_break, key_code, key_ascii};
    reads0 = reads_cnt;
    push(8'h1C);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (key_valid !== 1'b1 || {key_ext, key_break, key_code, key_ascii} !== snap) bad++;
    end
    checks++;
    if (bad != 0)
      begin errors++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    checks++;
    if (reads_cnt != reads0)
      begin errors++; $display("[TB] FAIL hold_no_read: got %0d pops expected 0", reads_cnt - reads0); end
    ack();
    wait_event(20, ok);
    checks++;
    if (!ok || {key_ext, key_code, key_ascii} !== {1'b0, 8'h1C, 8'h61})
      begin errors++; $display("[TB] FAIL after_hold: got ok=%0d %h expected %h", ok, {key_ext, key_code, key_ascii}, {1'b0, 8'h1C, 8'h61}); end
    ack();
    key_ack = 1'b1;
    steps(3);
    key_ack = 1'b0;
    push(8'h29);
    wait_event(20, ok);
    steps(3);
    checks++;
    if (!ok || key_valid !== 1'b1 || key_ascii !== 8'h20)
      begin errors++; $display("[TB] FAIL early_ack: got ok=%0d valid=%b ascii=%h expected 1/1/20", ok, key_valid, key_ascii); end
    ack();
  endtask

  task automatic test_timeout();
    bit ok;
    sends.delete();
    push(8'h58);
    wait_event(20, ok);
    checks++;
    if (!ok || capslock !== 1'b1)
      begin errors++; $display("[TB] FAIL timeout_caps: got ok=%0d caps=%b expected 1/1", ok, capslock); end
    ack();
    wait_sends(1, 20, ok);
    steps(150);
    checks++;
    if (sends.size() != 1)
      begin errors++; $display("[TB] FAIL timeout_sends: got %0d expected 1", sends.size()); end
    push(8'h1C);
    wait_event(20, ok);
    checks++;
    if (!ok || key_ascii !== 8'h41)
      begin errors++; $display("[TB] FAIL timeout_idle: got ok=%0d ascii=%h expected 1/41", ok, key_ascii); end
    ack();
    push(8'hF0);
    push(8'h58);
    wait_event(20, ok);
    ack();
    steps(10);
    checks++;
    if (sends.size() != 1)
      begin errors++; $display("[TB] FAIL timeout_no_retry: got %0d expected 1", sends.size()); end
  endtask

  task automatic test_reset_mid_led();
    bit ok;
    sends.delete();
    push(8'h58);
    wait_event(20, ok);
    ack();
    wait_sends(1, 20, ok);
    steps(5);
    rst = 1'b1;
    step();
    checks++;
    if ({kb_read, kb_send, kb_senddata, key_valid, key_code, key_ext, key_break, key_ascii, shift, ctrl, capslock} !== 32'h0)
      begin errors++; $display("[TB] FAIL mid_reset: got %h expected 0", {kb_read, kb_send, kb_senddata, key_valid, key_code, key_ext, key_break, key_ascii, shift, ctrl, capslock}); end
    rst = 1'b0;
    steps(200);
    checks++;
    if (sends.size() != 1)
      begin errors++; $display("[TB] FAIL post_reset_sends: got %0d expected 1", sends.size()); end
    push(8'hFA);
    push(8'hAA);
    steps(15);
    checks++;
    if (key_valid !== 1'b0 || fifo.size() != 0)
      begin errors++; $display("[TB] FAIL discard_fa_aa: got valid=%b left=%0d expected 0/0", key_valid, fifo.size()); end
    push(8'h1C);
    wait_event(20, ok);
    checks++;
    if (!ok || key_ascii !== 8'h61)
      begin errors++; $display("[TB] FAIL post_reset_key: got ok=%0d ascii=%h expected 1/61", ok, key_ascii); end
    ack();
  endtask

  initial begin
    rst = 1'b1;
    key_ack = 1'b0;
    refresh();
    test_reset();
    test_make_break();
    test_modifiers();
    test_capslock();
    test_typematic();
    test_ext_hold();
    test_timeout();
    test_reset_mid_led();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
